// File: rtl/serial_deser_pkg.sv
// Shared state encodings and limits for the serial_deser deserializer.
package serial_deser_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [1:0] S_SHIFT  = 2'd0;
  localparam logic [1:0] S_PARITY = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    ST_SHIFT  = S_SHIFT,
    ST_PARITY = S_PARITY,
    ST_HOLD   = S_HOLD
  } state_e;

endpackage

// File: rtl/serial_deser_bit_counter.sv
// Mod-N up-counter: load0 clears, en advances, saturates at N-1 (wrap only via load0).
module bit_counter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load0,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 tc
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load0)          cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/serial_deser.sv
// Serial-in/parallel-out deserializer, MSB first, valid/ready on both sides.
// Optional trailing even-parity bit per word when PARITY_CHECK_EN is defined.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             pout_perr
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_deser: WIDTH out of range 2..%0d", MAX_WIDTH);
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pvld_q, pvld_d;
  logic [CW-1:0]    cnt;
  logic             tc, cnt_en, cnt_ld0;
  logic             acc, out_free, load;

  assign sin_ready = (state_q != S_HOLD);
  assign acc       = sin_valid && sin_ready;
  assign out_free  = !pvld_q || pout_ready;

  bit_counter #(.N(WIDTH)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (cnt_en),
    .load0 (cnt_ld0),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    pout_d  = pout_q;
    load    = 1'b0;
    cnt_en  = 1'b0;
    cnt_ld0 = 1'b0;
    case (state_q)
      S_SHIFT: begin
        if (acc) begin
          sreg_d = {sreg_q[WIDTH-2:0], sin};
          cnt_en = 1'b1;
          if (tc) begin
`ifdef PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            // Bypass sreg so a free output takes the word on the same edge.
            if (out_free) begin
              load    = 1'b1;
              pout_d  = {sreg_q[WIDTH-2:0], sin};
              cnt_ld0 = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (acc) begin
          if (out_free) begin
            load    = 1'b1;
            pout_d  = sreg_q;
            cnt_ld0 = 1'b1;
            state_d = S_SHIFT;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
`endif
      S_HOLD: begin
        if (out_free) begin
          load    = 1'b1;
          pout_d  = sreg_q;
          cnt_ld0 = 1'b1;
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_SHIFT;
    endcase
    pvld_d = load ? 1'b1 : (pout_ready ? 1'b0 : pvld_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_SHIFT;
      sreg_q  <= '0;
      pout_q  <= '0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      pvld_q  <= pvld_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pvld_q;

`ifdef PARITY_CHECK_EN
  // par_q accumulates XOR of data bits; pend_q parks the error across HOLD.
  logic par_q, pend_q, perr_q, perr_bit;
  assign perr_bit = par_q ^ sin;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_q  <= 1'b0;
      pend_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (load)                         par_q <= 1'b0;
      else if (state_q == S_SHIFT && acc) par_q <= par_q ^ sin;
      if (state_q == S_PARITY && acc && !out_free) pend_q <= perr_bit;
      if (load) perr_q <= (state_q == S_HOLD) ? pend_q : perr_bit;
    end
  end

  assign pout_perr = perr_q;
`else
  assign pout_perr = 1'b0;
`endif

  a_cnt_range: assert property (@(posedge clk) disable iff (clr) cnt <= CW'(WIDTH - 1));

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser (WIDTH=8); parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_deser;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int BITS = W + 1;
`else
  localparam int BITS = W;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         pout_ready = 1'b0;
  logic         sin_ready, pout_valid, pout_perr;
  logic [W-1:0] pout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int npulse = 0;
  int tp0 = 0, tp1 = 0;

  serial_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .pout_perr  (pout_perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en && pout_valid && pout_ready) begin
      if (npulse == 0) tp0 = cyc;
      else if (npulse == 1) tp1 = cyc;
      npulse++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    chk("sin_ready_pre", 32'(sin_ready), 32'd1);
    sin = b;
    sin_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  // Sends one word MSB first; gap idle cycles between data bits, cnt checked in gaps.
  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap > 0 && i > 0) begin
        sin_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          chk("cnt_hold", 32'(dut.u_cnt.cnt), 32'(W - i));
        end
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit(^w);
`endif
    sin_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    #1 clr = 1'b1;
    #11;
    chk("rst_pout", 32'(pout), 32'h0);
    chk("rst_valid", 32'(pout_valid), 32'd0);
    chk("rst_perr", 32'(pout_perr), 32'd0);
    chk("rst_ready", 32'(sin_ready), 32'd1);
    chk("rst_cnt", 32'(dut.u_cnt.cnt), 32'd0);
    clr = 1'b0;
    @(posedge clk); #1;

    // single word, one-cycle valid pulse
    pout_ready = 1'b1;
    send_word(8'hA5, 0);
    chk("t2_valid", 32'(pout_valid), 32'd1);
    chk("t2_pout", 32'(pout), 32'hA5);
    chk("t2_perr", 32'(pout_perr), 32'd0);
    @(posedge clk); #1;
    chk("t2_pulse_end", 32'(pout_valid), 32'd0);

    // back-to-back words
    npulse = 0;
    mon_en = 1'b1;
    send_word(8'hA5, 0);
    chk("t3_pout0", 32'(pout), 32'hA5);
    send_word(8'h3C, 0);
    chk("t3_valid1", 32'(pout_valid), 32'd1);
    chk("t3_pout1", 32'(pout), 32'h3C);
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("t3_npulse", 32'(npulse), 32'd2);
    chk("t3_spacing", 32'(tp1 - tp0), 32'(BITS));

    // backpressure into HOLD
    pout_ready = 1'b0;
    send_word(8'hFF, 0);
    send_word(8'h01, 0);
    chk("t4_hold_ready", 32'(sin_ready), 32'd0);
    chk("t4_hold_pout", 32'(pout), 32'hFF);
    chk("t4_hold_valid", 32'(pout_valid), 32'd1);
    @(posedge clk); #1;
    chk("t4_stall_ready", 32'(sin_ready), 32'd0);
    chk("t4_stall_pout", 32'(pout), 32'hFF);
    pout_ready = 1'b1;
    @(posedge clk); #1;
    pout_ready = 1'b0;
    chk("t4_rel_pout", 32'(pout), 32'h01);
    chk("t4_rel_valid", 32'(pout_valid), 32'd1);
    chk("t4_rel_ready", 32'(sin_ready), 32'd1);

    // reset mid-word, between edges
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sin_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("t1_pout", 32'(pout), 32'h0);
    chk("t1_valid", 32'(pout_valid), 32'd0);
    chk("t1_ready", 32'(sin_ready), 32'd1);
    chk("t1_cnt", 32'(dut.u_cnt.cnt), 32'd0);
    #1 clr = 1'b0;
    @(posedge clk); #1;
    pout_ready = 1'b1;
    send_word(8'hC3, 0);
    chk("t1_word_valid", 32'(pout_valid), 32'd1);
    chk("t1_word_pout", 32'(pout), 32'hC3);

    // gapped input
    send_word(8'h5A, 2);
    chk("t5_valid", 32'(pout_valid), 32'd1);
    chk("t5_pout", 32'(pout), 32'h5A);
    @(posedge clk); #1;

`ifdef PARITY_CHECK_EN
    w = 8'hA5;
    for (int p = 0; p < 2; p++) begin
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
      chk("t6_valid_pre", 32'(pout_valid), 32'd0);
      send_bit(p[0]);
      sin_valid = 1'b0;
      chk("t6_valid", 32'(pout_valid), 32'd1);
      chk("t6_pout", 32'(pout), 32'hA5);
      chk("t6_perr", 32'(pout_perr), 32'(p));
      @(posedge clk); #1;
    end
`else
    w = 8'h00;
    chk("t6_perr_tied", 32'(pout_perr), 32'(w[0]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-in, parallel-out deserializer built from a WIDTH-bit D-flip-flop shift register and a mod-WIDTH bit counter. It consumes a one-bit serial stream, MSB first, under a valid/ready handshake. It presents each completed word on a registered parallel output with its own valid/ready handshake. It sits directly downstream of the single D flip-flop stage and turns its bit-per-clock output into words for the counter and shift-register blocks.

## Interface
- WIDTH, 8, data bits per word; legal range 2..32.
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-high reset.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin holds a bit this cycle.
- sin_ready  out  1  block accepts a bit this cycle.
- pout  out  WIDTH  assembled word; first received bit is pout[WIDTH-1].
- pout_valid  out  1  pout holds an unconsumed word.
- pout_ready  in  1  consumer takes pout this cycle.
- pout_perr  out  1  parity error flag accompanying pout; tied 0 without PARITY_CHECK_EN.

## Operation
- Bit accept: sin_valid && sin_ready at a rising edge.
  - sreg <= {sreg[WIDTH-2:0], sin}.
  - cnt increments.
- Word consume: pout_valid && pout_ready at a rising edge.
- Output register is free when !pout_valid || pout_ready.
- FSM states:
  - SHIFT: sin_ready=1; accepting data bits.
  - PARITY: only with PARITY_CHECK_EN; sin_ready=1; accepting the parity bit.
  - HOLD: sin_ready=0; word complete but the output register is occupied.
- SHIFT transitions:
  - Stays in SHIFT while cnt < WIDTH-1.
  - Accept at cnt==WIDTH-1 with the macro: go to PARITY.
  - Accept at cnt==WIDTH-1 without the macro, output free: load pout <= {sreg[WIDTH-2:0], sin}, set pout_valid=1, cnt <= 0, stay in SHIFT.
  - Accept at cnt==WIDTH-1 without the macro, output not free: sreg takes the last bit, go to HOLD.
- PARITY transitions:
  - On accept, output free: load pout and pout_perr, go to SHIFT.
  - On accept, output not free: latch the error bit, go to HOLD.
- HOLD: when the output is free, load pout from sreg, set pout_valid=1, cnt <= 0, go to SHIFT.
- pout_valid clears on a consume edge with no simultaneous load.
- Simultaneous consume and load: pout is replaced and pout_valid stays 1; no bubble, no loss.
- sin_valid low: sreg, cnt and state hold. Gaps are allowed anywhere in a word.
- cnt width is $clog2(WIDTH). It wraps to 0 only through a load, never by overflow.
- Reset values, applied immediately on clr and independent of clk:
  - pout=0, pout_valid=0, pout_perr=0.
  - sreg=0, cnt=0, state=SHIFT, so sin_ready=1.
- Reset mid-word discards the partial word. The first bit accepted after release is the MSB of a new word.

## Timing
- sin_ready is a combinational decode of state only; it never depends on pout_ready.
- pout, pout_valid and pout_perr are registered outputs.
- Latency:
  - Without the macro: last data bit accepted at edge N gives pout_valid=1 after edge N.
  - With the macro: the same relation holds for the parity bit.
- Throughput: one bit per clock. Continuous words of WIDTH bits, or WIDTH+1 with parity, run without stall while pout_ready=1.
- Stall cost: sin_ready is low from the edge entering HOLD until the edge that performs the HOLD load.

## Configuration
- Macro PARITY_CHECK_EN, defined: each word is followed by one even-parity bit.
  - pout_perr = ^data ^ parity_bit.
  - pout_perr is valid with pout_valid.
  - The PARITY state exists.
- Not defined:
  - Words are exactly WIDTH bits.
  - No PARITY state; pout_perr is constant 0.
  - No parity logic is synthesized.

## Structure
- Package serial_deser_pkg holds:
  - the state enum (SHIFT, PARITY, HOLD);
  - the localparam encodings;
  - a MAX_WIDTH=32 constant used for the WIDTH range check.
- Sub-module bit_counter is a mod-N up-counter.
  - Ports: clk, clr, en, load0, cnt, tc; tc is high at cnt==N-1.
  - Instantiated once with N=WIDTH.
- The shift register, output register, parity accumulator and FSM live in serial_deser.

## Test plan
1. Reset mid-word, WIDTH=8: accept 3 bits, assert clr between edges.
   - Outputs go 0 and sin_ready=1 immediately.
   - After release, bits 1,1,0,0,0,0,1,1 give pout=8'hC3.
2. Single word: bits 1,0,1,0,0,1,0,1 continuous, pout_ready=1.
   - pout=8'hA5 and pout_valid=1 for exactly one cycle after the 8th accept edge.
3. Back-to-back: 0xA5 then 0x3C with no gaps, pout_ready=1.
   - Two valid pulses 8 cycles apart.
   - sin_ready never drops.
4. Backpressure: pout_ready=0, send 0xFF then 0x01.
   - After the 16th accept, state=HOLD and sin_ready=0, with pout=8'hFF still valid.
   - Raise pout_ready for one cycle: at that edge pout becomes 8'h01, pout_valid stays 1, and sin_ready returns to 1.
5. Gapped input: 0x5A sent with sin_valid low for 2 cycles between every bit.
   - pout=8'h5A, and cnt holds during the gaps.
6. PARITY_CHECK_EN, WIDTH=8:
   - 0xA5 plus parity 0 gives pout_perr=0.
   - 0xA5 plus parity 1 gives pout_perr=1.
   - In both cases pout_valid rises after the 9th accept.
